la_udp_pkt_framer: RTL and testbench
====================================

LA_UDP_PKT_FRAMER -- requirements
Module: la_udp_pkt_framer

Interface
REQ-001 Parameter: PKT_PAYLOAD, 1024, maximum payload bytes per packet (range 1..65531).
REQ-002 Parameter: GAP_CYCLES, 64, idle clk cycles between packets (range 1..65535).
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: sample_run  in  1  level; a rising edge starts one transfer.
REQ-006 Port: sample_num  in  32  total bytes to transfer; sampled on the start edge.
REQ-007 Port: dout_done  in  1  level; upstream has written all capture bytes into the FIFO.
REQ-008 Port: fifo_ren  out  1  sample FIFO read strobe; data returns 1 cycle later.
REQ-009 Port: fifo_data  in  8  sample FIFO read data.
REQ-010 Port: almost_empty  in  1  sample FIFO almost-empty flag.
REQ-011 Port: tx_req  out  1  packet request to the UDP engine.
REQ-012 Port: tx_ack  in  1  UDP engine accepts the request.
REQ-013 Port: tx_len  out  16  UDP payload length = header 4 + payload bytes; valid while tx_req is high.
REQ-014 Port: tx_valid / tx_ready / tx_last  out/in/out  1 each  byte stream handshake.
REQ-015 Port: tx_data  out  8  stream byte.
REQ-016 Port: ethernet_read_done  out  1  level; transfer complete.
REQ-017 Port: busy  out  1  high in every state except IDLE and DONE.

Function
REQ-018 Rising-edge detect: sample_run registered once; start = sample_run & ~sample_run_d; start honoured only in IDLE or DONE, ignored otherwise.
REQ-019 On start: remaining <= sample_num, seq <= 0, ethernet_read_done <= 0; sample_num==0 -> DONE directly, no packet.
REQ-020 FSM states: IDLE, WAIT, REQ, HDR, PAY, GAP, DONE.
REQ-021 WAIT: plen = min(PKT_PAYLOAD, remaining) latched; -> REQ when (!almost_empty || dout_done).
REQ-022 REQ: tx_req=1, tx_len=plen+4; stay until tx_ack; tx_req drops the cycle after tx_ack is sampled; -> HDR.
REQ-023 HDR: emits seq[15:8], seq[7:0], plen[15:8], plen[7:0] in that order; -> PAY.
REQ-024 PAY: emits exactly plen FIFO bytes in FIFO order; tx_last=1 on the final payload byte only.
REQ-025 Byte transfer occurs iff tx_valid && tx_ready; tx_data/tx_last stable while tx_valid && !tx_ready.
REQ-026 Output path: 2-entry skid buffer; fifo_ren=1 only when in PAY, issued count < plen, (!almost_empty || dout_done), and buffered + in-flight bytes < 2.
REQ-027 Sustained throughput: 1 byte/cycle when tx_ready stays high and FIFO readable.
REQ-028 After the last payload transfer: remaining -= plen, seq += 1 (16-bit wrap 0xFFFF->0x0000); remaining==0 -> DONE, else -> GAP.
REQ-029 GAP: counts GAP_CYCLES cycles with tx_valid=0; -> WAIT.
REQ-030 DONE: ethernet_read_done=1 held until the next start or reset; fifo_ren=0.
REQ-031 Almost-empty asserted mid-packet with dout_done low: reads stall, tx_valid drops once buffer drains, packet resumes without byte loss or duplication.
REQ-032 tx_ack while not in REQ: ignored.
REQ-033 sample_num not a multiple of PKT_PAYLOAD: final packet carries the remainder.

Reset
REQ-034 rst_n low: FSM=IDLE; fifo_ren, tx_req, tx_valid, tx_last, ethernet_read_done, busy = 0; tx_data, tx_len, seq, remaining, counters, skid buffer = 0; sample_run_d = 0.
REQ-035 Reset mid-packet: all outputs reach reset values immediately; in-flight FIFO data discarded; no partial packet resumes after release.
REQ-036 sample_run held high through reset release: no start until it goes low and high again.

Verification
REQ-037 sample_num=2048, PKT_PAYLOAD=1024, tx_ready=1 -> 2 packets; tx_len=1028 each; headers 00 00 04 00 / 00 01 04 00; ethernet_read_done=1 after the 2nd tx_last.
REQ-038 sample_num=1500 -> packets of 1024 and 476 payload bytes; tx_len 1028 then 480; gap of exactly 64 cycles between them.
REQ-039 Random tx_ready (50%) plus almost_empty toggling, dout_done=0 -> payload equals FIFO byte sequence exactly; no duplicate or missing byte; tx_data stable while stalled.
REQ-040 sample_num=0 -> no tx_req; ethernet_read_done=1 two cycles after the sample_run edge.
REQ-041 rst_n pulsed low mid-PAY -> outputs reset the same cycle; a new start sends seq 0 cleanly.
REQ-042 Second sample_run edge during PAY -> ignored; transfer completes unchanged; a later edge in DONE restarts with seq=0.

Source files
------------

// File: rtl/la_udp_pkt_framer.sv
// UDP packet framer: slices a capture stream from the sample FIFO into
// packets of up to PKT_PAYLOAD bytes, each preceded by a 4-byte header
// (sequence number, payload length), with an idle gap between packets.
module la_udp_pkt_framer #(
  parameter int PKT_PAYLOAD = 1024,
  parameter int GAP_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_run,
  input  logic [31:0] sample_num,
  input  logic        dout_done,
  output logic        fifo_ren,
  input  logic [7:0]  fifo_data,
  input  logic        almost_empty,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [15:0] tx_len,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  tx_data,
  output logic        ethernet_read_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_HDR, S_PAY, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] MAX_PAY  = 16'(PKT_PAYLOAD);

  state_t      state, state_nxt;
  logic        run_d, armed;
  logic [31:0] remaining;
  logic [15:0] seq, plen, issued, gap_cnt;
  logic [1:0]  hdr_idx;
  logic        done_r;

  // Read pipeline: a byte requested this cycle lands in the skid buffer next cycle.
  logic        rd_vld_p1, rd_last_p1;
  // Two-entry skid buffer; entry 0 is the head that drives the stream.
  logic [7:0]  buf_data_p0, buf_data_p1;
  logic        buf_last_p0, buf_last_p1;
  logic [1:0]  buf_cnt;

  logic        start, start_ok, readable, pop, push, push_last, pay_end, room;
  logic        hdr_push;
  logic [7:0]  hdr_byte, push_data;
  logic [2:0]  occ;

  // Payload length of the next packet: the remaining count saturated at PKT_PAYLOAD.
  function automatic logic [15:0] clamp_len(input logic [31:0] rem);
    if (rem < {16'd0, MAX_PAY}) return rem[15:0];
    return MAX_PAY;
  endfunction

  // armed blocks a start until sample_run has been seen low after reset.
  assign start     = sample_run & ~run_d & armed;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign readable  = !almost_empty || dout_done;
  assign tx_valid  = (buf_cnt != 2'd0);
  assign tx_data   = buf_data_p0;
  assign tx_last   = buf_last_p0 & tx_valid;
  assign pop       = tx_valid && tx_ready;
  // Occupancy after this cycle's pop, counting the byte already in flight.
  assign occ       = {1'b0, buf_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign room      = (occ < 3'd2);
  assign push      = hdr_push || rd_vld_p1;
  assign push_data = hdr_push ? hdr_byte : fifo_data;
  assign push_last = hdr_push ? 1'b0 : rd_last_p1;
  assign pay_end   = (state == S_PAY) && pop && buf_last_p0;
  assign ethernet_read_done = done_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = (sample_num == 32'd0) ? S_DONE : S_WAIT;
      S_WAIT: if (readable) state_nxt = S_REQ;
      S_REQ:  if (tx_ack) state_nxt = S_HDR;
      S_HDR:  if (hdr_push && hdr_idx == 2'd3) state_nxt = S_PAY;
      S_PAY:  if (pay_end) state_nxt = (remaining == {16'd0, plen}) ? S_DONE : S_GAP;
      S_GAP:  if (gap_cnt == GAP_LAST) state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state outputs: request, header push, FIFO read strobe, busy.
  always_comb begin
    tx_req   = 1'b0;
    tx_len   = '0;
    busy     = 1'b1;
    fifo_ren = 1'b0;
    hdr_push = 1'b0;
    case (hdr_idx)
      2'd0:    hdr_byte = seq[15:8];
      2'd1:    hdr_byte = seq[7:0];
      2'd2:    hdr_byte = plen[15:8];
      default: hdr_byte = plen[7:0];
    endcase
    case (state)
      S_IDLE, S_DONE: busy = 1'b0;
      S_REQ: begin
        tx_req = 1'b1;
        tx_len = plen + 16'd4;
      end
      S_HDR: hdr_push = room;
      S_PAY: fifo_ren = (issued < plen) && readable && room;
      default: ;
    endcase
  end

  // Start edge detection and transfer bookkeeping (remaining bytes, sequence, done flag).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_d     <= 1'b0;
      armed     <= 1'b0;
      remaining <= '0;
      seq       <= '0;
      plen      <= '0;
      done_r    <= 1'b0;
    end else begin
      run_d <= sample_run;
      armed <= armed | ~sample_run;
      if (state == S_WAIT) plen <= clamp_len(remaining);
      if (start_ok) begin
        remaining <= sample_num;
        seq       <= '0;
        done_r    <= 1'b0;
      end else begin
        if (pay_end) begin
          remaining <= remaining - {16'd0, plen};
          seq       <= seq + 16'd1;
        end
        if (state == S_DONE) done_r <= 1'b1;
      end
    end
  end

  // Per-packet counters: header index, payload reads issued, gap length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx <= '0;
      issued  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state != S_HDR) hdr_idx <= '0;
      else if (hdr_push)  hdr_idx <= hdr_idx + 2'd1;
      if (state != S_PAY) issued <= '0;
      else if (fifo_ren)  issued <= issued + 16'd1;
      if (state != S_GAP) gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // Read pipeline and skid buffer; the head entry holds still while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1   <= 1'b0;
      rd_last_p1  <= 1'b0;
      buf_data_p0 <= '0;
      buf_data_p1 <= '0;
      buf_last_p0 <= 1'b0;
      buf_last_p1 <= 1'b0;
      buf_cnt     <= '0;
    end else begin
      rd_vld_p1  <= fifo_ren;
      rd_last_p1 <= fifo_ren && (issued == plen - 16'd1);
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_data_p0 <= push_data;
            buf_last_p0 <= push_last;
          end else begin
            buf_data_p1 <= push_data;
            buf_last_p1 <= push_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data_p0 <= buf_data_p1;
          buf_last_p0 <= buf_last_p1;
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_data_p0 <= push_data;
            buf_last_p0 <= push_last;
          end else begin
            buf_data_p0 <= buf_data_p1;
            buf_last_p0 <= buf_last_p1;
            buf_data_p1 <= push_data;
            buf_last_p1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_udp_pkt_framer.sv
// Bench for la_udp_pkt_framer: FIFO and UDP-engine responders, a stream
// monitor, and a packet-level reference model built from the framing rules.
module tb_la_udp_pkt_framer;

  localparam int P     = 1024;
  localparam int G     = 64;
  localparam int MEMSZ = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_run = 1'b0;
  logic [31:0] sample_num = '0;
  logic        dout_done = 1'b0;
  logic        fifo_ren;
  logic [7:0]  fifo_data = '0;
  logic        almost_empty = 1'b0;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic [15:0] tx_len;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic [7:0]  tx_data;
  logic        ethernet_read_done;
  logic        busy;

  la_udp_pkt_framer #(.PKT_PAYLOAD(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .sample_run(sample_run), .sample_num(sample_num),
    .dout_done(dout_done), .fifo_ren(fifo_ren), .fifo_data(fifo_data),
    .almost_empty(almost_empty), .tx_req(tx_req), .tx_ack(tx_ack), .tx_len(tx_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .tx_data(tx_data),
    .ethernet_read_done(ethernet_read_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [MEMSZ];
  int          ptr = 0;
  bit          ren_q = 0;
  int          cyc = 0;
  logic [8:0]  sq[$], exq[$];
  int          cq[$], rq[$];
  logic [15:0] lq[$], exl[$];
  int          stall_viol = 0;
  bit          pv = 0, pr = 0, preq = 0;
  logic [7:0]  pd = '0;
  logic        pl = 1'b0;
  bit          rnd_ready = 0, rnd_ae = 0, ack_auto = 0, ack_rnd = 0;
  logic        ready_fix = 1'b1, ae_fix = 1'b0;
  int          total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment responders, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (ren_q) begin
      fifo_data = mem[ptr % MEMSZ];
      ptr++;
    end
    if (rnd_ready) tx_ready = ($urandom_range(0, 1) == 1);
    else           tx_ready = ready_fix;
    if (rnd_ae) almost_empty = ($urandom_range(0, 3) == 0);
    else        almost_empty = ae_fix;
    if (ack_auto) tx_ack = tx_req && (!ack_rnd || $urandom_range(0, 2) == 0);
  end

  // Monitor on the falling edge: transfers, requests, stall stability.
  always @(negedge clk) begin
    ren_q = fifo_ren && rst_n;
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        sq.push_back({tx_last, tx_data});
        cq.push_back(cyc);
      end
      if (pv && !pr && (!tx_valid || tx_data !== pd || tx_last !== pl)) stall_viol++;
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
      if (tx_req && !preq) rq.push_back(cyc);
      if (tx_req && tx_ack) lq.push_back(tx_len);
      preq = tx_req;
    end else begin
      pv = 0;
      preq = 0;
    end
  end

  task automatic clear_mon();
    sq.delete(); cq.delete(); rq.delete(); lq.delete();
    exq.delete(); exl.delete();
    stall_viol = 0;
  endtask

  // Reference: packets of min(P, remaining) bytes, header {seq, len}, FIFO bytes in order.
  task automatic build_exp(input int n, input int base);
    int rem, s, off, len;
    rem = n; s = 0; off = base;
    while (rem > 0) begin
      len = (rem < P) ? rem : P;
      exq.push_back({1'b0, 8'((s >> 8) & 255)});
      exq.push_back({1'b0, 8'(s & 255)});
      exq.push_back({1'b0, 8'((len >> 8) & 255)});
      exq.push_back({1'b0, 8'(len & 255)});
      for (int j = 0; j < len; j++)
        exq.push_back({(j == len - 1), mem[(off + j) % MEMSZ]});
      exl.push_back(16'(len + 4));
      off += len; rem -= len; s = (s + 1) % 65536;
    end
  endtask

  function automatic int first_mismatch();
    int n;
    n = (sq.size() < exq.size()) ? sq.size() : exq.size();
    for (int i = 0; i < n; i++) if (sq[i] !== exq[i]) return i;
    if (sq.size() != exq.size()) return n;
    return -1;
  endfunction

  function automatic bit lens_match();
    if (lq.size() != exl.size()) return 0;
    for (int i = 0; i < lq.size(); i++) if (lq[i] !== exl[i]) return 0;
    return 1;
  endfunction

  task automatic start_xfer(input int n);
    @(posedge clk); #1 sample_run = 1'b0;
    @(posedge clk); #1 sample_num = n; sample_run = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ethernet_read_done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sq.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({fifo_ren, tx_req, tx_valid, tx_last} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {fifo_ren, tx_req, tx_valid, tx_last});
    end
    total++;
    if ({ethernet_read_done, busy} !== 2'b0) begin
      bad++; $display("FAIL reset_status: got %b want 00", {ethernet_read_done, busy});
    end
    total++;
    if ({tx_data, tx_len} !== 24'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {tx_data, tx_len});
    end
    rst_n = 1'b1;
    @(posedge clk); #1 tx_ack = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_req, busy} !== 2'b0) begin
      bad++; $display("FAIL ack_in_idle: got %b want 00", {tx_req, busy});
    end
    @(posedge clk); #1 tx_ack = 1'b0;
  endtask

  task automatic test_two_packets();
    bit ok; int mm, viol;
    rnd_ready = 0; ready_fix = 1; rnd_ae = 0; ae_fix = 0; ack_auto = 1; ack_rnd = 0;
    @(posedge clk); #2 clear_mon(); build_exp(2048, ptr);
    start_xfer(2048); wait_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL two_done: got timeout want done"); end
    total++;
    if (lq.size() != 2 || lq[0] !== 16'd1028 || lq[1] !== 16'd1028) begin
      bad++; $display("FAIL two_len: got n=%0d first=%0d want 2x1028", lq.size(), (lq.size() > 0) ? lq[0] : 0);
    end
    mm = first_mismatch();
    total++;
    if (mm != -1) begin
      bad++; $display("FAIL two_stream: got mismatch at %0d (size %0d) want size %0d", mm, sq.size(), exq.size());
    end
    total++;
    if (sq.size() != 2056 || {sq[0], sq[1], sq[2], sq[3]} !== {9'h000, 9'h000, 9'h004, 9'h000}
        || {sq[1028], sq[1029], sq[1030], sq[1031]} !== {9'h000, 9'h001, 9'h004, 9'h000}) begin
      bad++; $display("FAIL two_headers: got size %0d want 2056 with 00 00 04 00 / 00 01 04 00", sq.size());
    end
    viol = 0;
    if (cq.size() == 2056)
      for (int p = 0; p < 2; p++)
        for (int j = 1; j < P; j++)
          if (cq[p * 1028 + 4 + j] != cq[p * 1028 + 3 + j] + 1) viol++;
    total++;
    if (cq.size() != 2056 || viol != 0) begin
      bad++; $display("FAIL two_throughput: got %0d bubbles want 0", viol);
    end
  endtask

  task automatic test_remainder();
    bit ok; int mm, idle;
    @(posedge clk); #2 clear_mon(); build_exp(1500, ptr);
    start_xfer(1500); wait_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rem_done: got timeout want done"); end
    total++;
    if (!lens_match()) begin
      bad++; $display("FAIL rem_len: got n=%0d last=%0d want 1028,480", lq.size(), (lq.size() > 0) ? lq[lq.size() - 1] : 0);
    end
    mm = first_mismatch();
    total++;
    if (mm != -1) begin
      bad++; $display("FAIL rem_stream: got mismatch at %0d (size %0d) want size %0d", mm, sq.size(), exq.size());
    end
    // Idle cycles from the last byte of packet 0 to the request of packet 1: the gap plus one WAIT cycle.
    idle = (cq.size() > 1027 && rq.size() == 2) ? rq[1] - cq[1027] - 1 : -1;
    total++;
    if (idle != G + 1) begin
      bad++; $display("FAIL rem_gap: got %0d idle cycles want %0d", idle, G + 1);
    end
  endtask

  task automatic test_random_stall();
    bit ok; int mm, n;
    rnd_ready = 1; rnd_ae = 1; dout_done = 0; ack_rnd = 1;
    n = 1300 + $urandom_range(0, 700);
    @(posedge clk); #2 clear_mon(); build_exp(n, ptr);
    start_xfer(n); wait_done(40000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rnd_done: got timeout want done"); end
    mm = first_mismatch();
    total++;
    if (mm != -1) begin
      bad++; $display("FAIL rnd_stream: got mismatch at %0d (size %0d) want size %0d", mm, sq.size(), exq.size());
    end
    total++;
    if (!lens_match()) begin bad++; $display("FAIL rnd_len: got %0d lengths want %0d", lq.size(), exl.size()); end
    total++;
    if (stall_viol != 0) begin bad++; $display("FAIL rnd_stable: got %0d changes while stalled want 0", stall_viol); end
    rnd_ready = 0; rnd_ae = 0; ack_rnd = 0;
  endtask

  task automatic test_zero();
    @(posedge clk); #2 clear_mon();
    start_xfer(0);
    @(posedge clk); @(negedge clk);
    total++;
    if (ethernet_read_done !== 1'b0) begin bad++; $display("FAIL zero_clear: got %b want 0", ethernet_read_done); end
    @(posedge clk); @(negedge clk);
    total++;
    if (ethernet_read_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", ethernet_read_done); end
    repeat (8) @(negedge clk);
    total++;
    if (rq.size() != 0 || sq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_nopkt: got req=%0d bytes=%0d busy=%b want 0 0 0", rq.size(), sq.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int mm;
    @(posedge clk); #2 clear_mon();
    start_xfer(2048); wait_bytes(200, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_reach: got timeout want 200 bytes"); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_ren, tx_req, tx_valid, tx_last, ethernet_read_done, busy, tx_data, tx_len} !== 30'h0) begin
      bad++; $display("FAIL rst_immediate: got %b%b%b%b%b%b want all 0", fifo_ren, tx_req, tx_valid, tx_last, ethernet_read_done, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    total++;
    if (rq.size() != 0 || sq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_held_run: got req=%0d bytes=%0d busy=%b want no start", rq.size(), sq.size(), busy);
    end
    clear_mon(); build_exp(300, ptr);
    start_xfer(300); wait_done(5000, ok);
    mm = first_mismatch();
    total++;
    if (!ok || mm != -1) begin
      bad++; $display("FAIL rst_restart: got done=%b mismatch at %0d want clean seq 0 packet", ok, mm);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok; int mm;
    @(posedge clk); #2 clear_mon(); build_exp(1100, ptr);
    start_xfer(1100); wait_bytes(100, 5000, ok);
    @(posedge clk); #1 sample_run = 1'b0;
    @(posedge clk); #1 sample_num = 7; sample_run = 1'b1;
    wait_done(20000, ok);
    mm = first_mismatch();
    total++;
    if (!ok || mm != -1 || !lens_match()) begin
      bad++; $display("FAIL ign_stream: got done=%b mismatch at %0d lens=%0d want unchanged 1100-byte transfer", ok, mm, lq.size());
    end
    repeat (5) @(negedge clk);
    total++;
    if (ethernet_read_done !== 1'b1) begin bad++; $display("FAIL ign_hold: got %b want 1", ethernet_read_done); end
    clear_mon(); build_exp(5, ptr);
    start_xfer(5); wait_done(5000, ok);
    mm = first_mismatch();
    total++;
    if (!ok || mm != -1 || sq.size() < 2 || {sq[0], sq[1]} !== 18'h0) begin
      bad++; $display("FAIL ign_restart: got done=%b mismatch at %0d want seq 0 packet of 5", ok, mm);
    end
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    test_reset();
    test_two_packets();
    test_remainder();
    test_random_stall();
    test_zero();
    test_reset_mid();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
